ser_frame_rx: RTL and testbench
===============================

SER_FRAME_RX -- requirements
Module: ser_frame_rx

Interface
REQ-001 Parameter MSB_FIRST, default 1, meaning: 1 = first data bit received is dout[7]; 0 = first data bit is dout[0].
REQ-002 Parameter PARITY_EN, default 1, meaning: 1 = frame carries an even-parity bit after the data; 0 = no parity bit.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 sin  input  1  serial line, fed from the upstream shift register's serial output; idle level 1.
REQ-006 en  input  1  bit strobe; sin is sampled only on edges where en=1.
REQ-007 dack  input  1  consumer acknowledge for the held byte.
REQ-008 clr  input  1  clears the sticky error flags.
REQ-009 dout  output  8  last accepted data byte.
REQ-010 dvalid  output  1  dout holds an unacknowledged byte.
REQ-011 busy  output  1  high in every state other than IDLE.
REQ-012 perr  output  1  sticky parity-error flag.
REQ-013 ferr  output  1  sticky framing-error flag (stop bit not 1).
REQ-014 ovr  output  1  sticky overrun flag.
REQ-015 frame_cnt  output  8  count of accepted frames.

Function
REQ-016 Frame format: start bit 0, then 8 data bits, then the parity bit if PARITY_EN=1, then stop bit 1.
REQ-017 The state machine SHALL have four states, IDLE, DATA, PARITY and STOP; every transition SHALL occur only on an edge where en=1.
REQ-018 IDLE: sin=0 -> DATA with bit counter=0; sin=1 -> stay in IDLE.
REQ-019 DATA: shift sin into the shift register in the MSB_FIRST order; after the 8th sampled bit go to PARITY if PARITY_EN=1, else go to STOP.
REQ-020 PARITY: capture sin; parity is bad when XOR(8 data bits, sin)=1; go to STOP.
REQ-021 STOP: evaluate the frame; go to IDLE.
REQ-022 In STOP, with sin=0: discard the byte, set ferr, leave dout/dvalid/frame_cnt unchanged.
REQ-023 In STOP, with sin=1 and bad parity: discard the byte, set perr.
REQ-024 In STOP, with sin=1, good parity and dvalid=0: load dout, set dvalid=1, increment frame_cnt.
REQ-025 In STOP, with sin=1, good parity and dvalid=1 without a same-edge dack: discard the new byte, set ovr, keep the old dout.
REQ-026 dack=1 while dvalid=1 SHALL clear dvalid on that edge; dack while dvalid=0 SHALL have no effect.
REQ-027 dack and a good STOP completion on the same edge: the new byte is loaded, dvalid stays 1, no ovr.
REQ-028 Latency: dout/dvalid SHALL be updated on the same edge that samples the stop bit.
REQ-029 frame_cnt SHALL be 8-bit modular: 255 + 1 -> 0.
REQ-030 clr=1 SHALL clear perr, ferr and ovr on that edge; set takes priority when a set and clr occur on the same edge.
REQ-031 en=0 SHALL hold all state, the bit counter, the shift register and all outputs, except for dack and clr effects.
REQ-032 A start bit SHALL be recognized only in IDLE; the STOP-to-IDLE edge itself SHALL never start a new frame.

Reset
REQ-033 rst=1 at a clock edge SHALL force: state=IDLE, bit counter=0, shift register=0, dout=8'h00, dvalid=0, busy=0, perr=0, ferr=0, ovr=0, frame_cnt=0.
REQ-034 rst SHALL take priority over en, dack and clr.
REQ-035 rst asserted mid-frame SHALL abort the frame with no flag or count change beyond the reset values.
REQ-036 After rst, the next frame SHALL be received normally.

Verification
REQ-037 PARITY_EN=1, MSB_FIRST=1, en=1 every cycle, frame 0,1001_0000,0,1 -> dout=8'h90, dvalid=1 on the stop edge, frame_cnt=1, no flags.
REQ-038 Frame for 8'h11 with parity bit 1 -> perr=1, dvalid stays 0, frame_cnt unchanged; clr pulse -> perr=0.
REQ-039 Frame for 8'h62 with stop bit 0 -> ferr=1, dout unchanged.
REQ-040 Two good frames 8'h50 then 8'h43 with no dack -> dout=8'h50, ovr=1.
REQ-041 Repeat the REQ-040 sequence with dack on the second frame's stop edge -> dout=8'h43, dvalid=1, ovr=0.
REQ-042 rst after the 4th data bit -> all outputs at reset values; the next 8'hA5 frame is received correctly.
REQ-043 en toggling 1-of-3 cycles -> same results as REQ-037.
REQ-044 256 good frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/ser_frame_rx.sv
// ser_frame_rx: strobed serial frame receiver.
// A frame is a start bit (0), eight data bits, an optional even-parity bit,
// and a stop bit (1). The line is sampled only on edges where en=1.
// A good frame is held in dout until the consumer acknowledges it.
// Frames that are bad or that overrun the held byte raise sticky flags.
//
// Ports:
//   clk       in   clock; all state changes on the rising edge
//   rst       in   synchronous active-high reset
//   sin       in   serial line, idles high
//   en        in   bit strobe
//   dack      in   consumer acknowledge for the held byte
//   clr       in   clears perr/ferr/ovr
//   dout      out  [7:0] last accepted byte
//   dvalid    out  dout holds an unacknowledged byte
//   busy      out  receiver is inside a frame (state other than IDLE)
//   perr      out  sticky parity error
//   ferr      out  sticky framing error
//   ovr       out  sticky overrun
//   frame_cnt out  [7:0] modular count of accepted frames
module ser_frame_rx #(
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  input  logic       en,
  input  logic       dack,
  input  logic       clr,
  output logic [7:0] dout,
  output logic       dvalid,
  output logic       busy,
  output logic       perr,
  output logic       ferr,
  output logic       ovr,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_n;
  logic [2:0]  bit_cnt_r;
  logic [7:0]  shift_r;
  logic        par_bad_r;
  logic [7:0]  dout_r;
  logic        dvalid_r;
  logic        busy_r;
  logic        perr_r;
  logic        ferr_r;
  logic        ovr_r;
  logic [7:0]  frame_cnt_r;

  logic        stop_eval_s;
  logic        frame_ok_s;
  logic        load_s;
  logic        ferr_set_s;
  logic        perr_set_s;
  logic        ovr_set_s;

  // Even parity check: the data bits plus the parity bit must XOR to zero.
  function automatic logic parity_bad(input logic [7:0] data, input logic pbit);
    return ^{data, pbit};
  endfunction

  // Next-state logic; the machine only advances on strobed edges.
  always_comb begin
    state_n = state_r;
    if (en) begin
      case (state_r)
        IDLE: begin
          if (!sin) begin
            state_n = DATA;
          end else begin
            state_n = IDLE;
          end
        end
        DATA: begin
          if (bit_cnt_r == 3'd7) begin
            if (PARITY_EN) begin
              state_n = PARITY;
            end else begin
              state_n = STOP;
            end
          end else begin
            state_n = DATA;
          end
        end
        PARITY:  state_n = STOP;
        STOP:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Frame completion decode: the stop edge either accepts the byte or flags why not.
  // A same-edge dack frees the holding register, so a good frame then loads
  // instead of overrunning.
  always_comb begin
    stop_eval_s = en && (state_r == STOP);
    frame_ok_s  = stop_eval_s && sin && !par_bad_r;
    load_s      = frame_ok_s && (!dvalid_r || dack);
    ferr_set_s  = stop_eval_s && !sin;
    perr_set_s  = stop_eval_s && sin && par_bad_r;
    ovr_set_s   = frame_ok_s && dvalid_r && !dack;
  end

  // State register and registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_r  <= (state_n != IDLE);
    end
  end

  // Bit counter, shift register and captured parity result.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      par_bad_r <= 1'b0;
    end else if (en) begin
      case (state_r)
        IDLE: begin
          if (!sin) begin
            bit_cnt_r <= 3'd0;
            par_bad_r <= 1'b0;
          end
        end
        DATA: begin
          if (MSB_FIRST) begin
            shift_r <= {shift_r[6:0], sin};
          end else begin
            shift_r <= {sin, shift_r[7:1]};
          end
          bit_cnt_r <= bit_cnt_r + 3'd1;
        end
        PARITY: par_bad_r <= parity_bad(shift_r, sin);
        default: ;
      endcase
    end
  end

  // Holding register, valid flag and accepted-frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r      <= 8'h00;
      dvalid_r    <= 1'b0;
      frame_cnt_r <= 8'h00;
    end else if (load_s) begin
      dout_r      <= shift_r;
      dvalid_r    <= 1'b1;
      frame_cnt_r <= frame_cnt_r + 8'd1;
    end else if (dack) begin
      dvalid_r    <= 1'b0;
    end
  end

  // Sticky error flags; a set on the same edge as clr wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      perr_r <= 1'b0;
      ferr_r <= 1'b0;
      ovr_r  <= 1'b0;
    end else begin
      perr_r <= perr_set_s | (perr_r & ~clr);
      ferr_r <= ferr_set_s | (ferr_r & ~clr);
      ovr_r  <= ovr_set_s  | (ovr_r  & ~clr);
    end
  end

  assign dout      = dout_r;
  assign dvalid    = dvalid_r;
  assign busy      = busy_r;
  assign perr      = perr_r;
  assign ferr      = ferr_r;
  assign ovr       = ovr_r;
  assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_ser_frame_rx.sv
// Directed self-checking bench for ser_frame_rx (MSB first, even parity).
module tb_ser_frame_rx;

  logic       clk;
  logic       rst;
  logic       sin;
  logic       en;
  logic       dack;
  logic       clr;
  logic [7:0] dout;
  logic       dvalid;
  logic       busy;
  logic       perr;
  logic       ferr;
  logic       ovr;
  logic [7:0] frame_cnt;

  int checks;
  int failures;

  ser_frame_rx #(.MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .sin(sin), .en(en), .dack(dack), .clr(clr),
    .dout(dout), .dvalid(dvalid), .busy(busy), .perr(perr), .ferr(ferr),
    .ovr(ovr), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One strobed bit followed by gap idle-strobe cycles holding the line.
  task automatic send_bit(input logic b, input int gap);
    sin = b;
    en  = 1'b1;
    tick();
    en  = 1'b0;
    for (int g = 0; g < gap; g++) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb,
                            input logic dk, input int gap);
    send_bit(1'b0, gap);
    for (int i = 7; i >= 0; i--) send_bit(d[i], gap);
    send_bit(pbit, gap);
    dack = dk;
    sin  = stopb;
    en   = 1'b1;
    tick();
    en   = 1'b0;
    dack = 1'b0;
    sin  = 1'b1;
    for (int g = 0; g < gap; g++) tick();
  endtask

  task automatic pulse_dack();
    dack = 1'b1;
    tick();
    dack = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dout"}, 32'(dout), 32'h00);
    chk({tag, "_dvalid"}, 32'(dvalid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_perr"}, 32'(perr), 32'd0);
    chk({tag, "_ferr"}, 32'(ferr), 32'd0);
    chk({tag, "_ovr"}, 32'(ovr), 32'd0);
    chk({tag, "_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    sin  = 1'b1;
    en   = 1'b0;
    dack = 1'b0;
    clr  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_vals("reset");

    // Good frame 0x90, parity 0; result visible right after the stop edge.
    send_bit(1'b0, 0);
    chk("busy_in_frame", 32'(busy), 32'd1);
    for (int i = 7; i >= 0; i--) begin
      d = 8'h90;
      send_bit(d[i], 0);
    end
    send_bit(1'b0, 0);
    chk("pre_stop_dvalid", 32'(dvalid), 32'd0);
    send_bit(1'b1, 0);
    chk("f90_dout", 32'(dout), 32'h90);
    chk("f90_dvalid", 32'(dvalid), 32'd1);
    chk("f90_cnt", 32'(frame_cnt), 32'd1);
    chk("f90_busy", 32'(busy), 32'd0);
    chk("f90_flags", {29'd0, perr, ferr, ovr}, 32'd0);
    pulse_dack();
    chk("dack_clears", 32'(dvalid), 32'd0);
    pulse_dack();
    chk("dack_idle_noeffect", 32'(dvalid), 32'd0);

    // 0x11 with wrong parity bit 1.
    send_frame(8'h11, 1'b1, 1'b1, 1'b0, 0);
    chk("par_perr", 32'(perr), 32'd1);
    chk("par_dvalid", 32'(dvalid), 32'd0);
    chk("par_cnt", 32'(frame_cnt), 32'd1);
    chk("par_dout", 32'(dout), 32'h90);
    pulse_clr();
    chk("par_clr", 32'(perr), 32'd0);

    // 0x62 (parity 1) with stop bit 0.
    send_frame(8'h62, 1'b1, 1'b0, 1'b0, 0);
    chk("frm_ferr", 32'(ferr), 32'd1);
    chk("frm_dout", 32'(dout), 32'h90);
    chk("frm_dvalid", 32'(dvalid), 32'd0);
    chk("frm_cnt", 32'(frame_cnt), 32'd1);
    chk("frm_busy", 32'(busy), 32'd0);
    tick();
    chk("frm_no_restart", 32'(busy), 32'd0);
    pulse_clr();
    chk("frm_clr", 32'(ferr), 32'd0);

    // Overrun: 0x50 then 0x43 without dack.
    send_frame(8'h50, 1'b0, 1'b1, 1'b0, 0);
    chk("ovr_first", 32'(dout), 32'h50);
    send_frame(8'h43, 1'b1, 1'b1, 1'b0, 0);
    chk("ovr_dout", 32'(dout), 32'h50);
    chk("ovr_flag", 32'(ovr), 32'd1);
    chk("ovr_cnt", 32'(frame_cnt), 32'd2);
    chk("ovr_dvalid", 32'(dvalid), 32'd1);
    pulse_dack();
    pulse_clr();
    chk("ovr_clr", 32'(ovr), 32'd0);

    // Same sequence with dack on the second stop edge.
    send_frame(8'h50, 1'b0, 1'b1, 1'b0, 0);
    send_frame(8'h43, 1'b1, 1'b1, 1'b1, 0);
    chk("sameedge_dout", 32'(dout), 32'h43);
    chk("sameedge_dvalid", 32'(dvalid), 32'd1);
    chk("sameedge_ovr", 32'(ovr), 32'd0);
    chk("sameedge_cnt", 32'(frame_cnt), 32'd4);

    // Reset after the fourth data bit of 0xA5, then receive 0xA5 cleanly.
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    rst = 1'b1;
    dack = 1'b1;
    clr = 1'b1;
    en = 1'b1;
    tick();
    rst = 1'b0;
    dack = 1'b0;
    clr = 1'b0;
    en = 1'b0;
    sin = 1'b1;
    chk_reset_vals("midrst");
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 0);
    chk("postrst_dout", 32'(dout), 32'hA5);
    chk("postrst_dvalid", 32'(dvalid), 32'd1);
    chk("postrst_cnt", 32'(frame_cnt), 32'd1);
    pulse_dack();

    // Strobe active one cycle in three.
    send_frame(8'h90, 1'b0, 1'b1, 1'b0, 2);
    chk("slow_dout", 32'(dout), 32'h90);
    chk("slow_dvalid", 32'(dvalid), 32'd1);
    chk("slow_cnt", 32'(frame_cnt), 32'd2);
    chk("slow_flags", {29'd0, perr, ferr, ovr}, 32'd0);
    pulse_dack();

    // 256 good frames from reset: counter reaches 255 then wraps to 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 255; n++) begin
      d = 8'(n);
      send_frame(d, ^d, 1'b1, 1'b1, 0);
    end
    chk("cnt_255", 32'(frame_cnt), 32'd255);
    chk("cnt_255_ovr", 32'(ovr), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 0);
    chk("cnt_wrap", 32'(frame_cnt), 32'd0);
    chk("cnt_wrap_dout", 32'(dout), 32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
